// File: rtl/delay_line_pkg.sv
// Shared types and constants for the delay-line controller and its RAM.
package delay_line_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam logic [7:0] DEFAULT_DELAY = 8'd16;
  localparam int MIN_TICK_PERIOD = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    RW   = 3'd3,
    OUT  = 3'd4
  } state_e;

endpackage

// File: rtl/delay_line_ram.sv
// Single-port synchronous RAM, one-cycle read latency, read returns old data on a same-cycle write.
module delay_line_ram
  import delay_line_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/delay_line_controller.sv
// Sequences one write and one delayed read of a circular-buffer RAM per sample tick,
// masking samples that were never written while the buffer fills.
module delay_line_controller
  import delay_line_pkg::*;
#(
  parameter int              ADDR_W        = DEF_ADDR_W,
  parameter int              DATA_W        = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] DEFAULT_DELAY = ADDR_W'(delay_line_pkg::DEFAULT_DELAY)
) (
  input  logic              qzt_clk,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic [DATA_W-1:0] adc_data,
  input  logic [ADDR_W-1:0] delay_set,
  input  logic              delay_load,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_valid,
  output logic              busy,
  output logic              overrun,
  output logic [ADDR_W-1:0] delay_cur,
  output state_e            dbg_state
);

  localparam logic [ADDR_W:0] FILL_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q;
  logic              tick_old_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W:0]   fill_cnt_q;
  logic [ADDR_W-1:0] delay_cur_q;
  logic              pend_q;
  logic [ADDR_W-1:0] pend_val_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic [DATA_W-1:0] dac_data_q;
  logic              dac_valid_q;
  logic              overrun_q;

  logic              tick_edge_d;
  logic [ADDR_W:0]   fill_cnt_d;
  logic [ADDR_W-1:0] rd_addr_d;

  assign tick_edge_d = ~tick_old_q & sample_tick;
  assign fill_cnt_d  = (fill_cnt_q == FILL_MAX) ? fill_cnt_q : fill_cnt_q + 1'b1;
  // Natural modulo wrap gives the circular-buffer read position.
  assign rd_addr_d   = wr_ptr_q - delay_cur_q;

  always_ff @(posedge qzt_clk) begin
    // Edge history keeps tracking through reset so a held-high tick is not an edge.
    tick_old_q <= sample_tick;
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      delay_cur_q <= DEFAULT_DELAY;
      pend_q      <= 1'b0;
      pend_val_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      dac_data_q  <= '0;
      dac_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      dac_valid_q <= 1'b0;
      if (tick_edge_d && state_q != IDLE) overrun_q <= 1'b1;
      if (delay_load && state_q inside {WR, RD, RW}) begin
        pend_q     <= 1'b1;
        pend_val_q <= delay_set;
      end
      case (state_q)
        IDLE: begin
          if (delay_load) delay_cur_q <= delay_set;
          if (tick_edge_d) begin
            ram_we_q    <= 1'b1;
            ram_addr_q  <= wr_ptr_q;
            ram_wdata_q <= adc_data;
            state_q     <= WR;
          end
        end
        WR: begin
          ram_we_q   <= 1'b0;
          ram_addr_q <= rd_addr_d;
          fill_cnt_q <= fill_cnt_d;
          state_q    <= RD;
        end
        RD: state_q <= RW;
        RW: begin
          dac_data_q  <= (fill_cnt_q > {1'b0, delay_cur_q}) ? ram_rdata : '0;
          dac_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
          if (delay_load)  delay_cur_q <= delay_set;
          else if (pend_q) delay_cur_q <= pend_val_q;
          pend_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign dac_data  = dac_data_q;
  assign dac_valid = dac_valid_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;
  assign delay_cur = delay_cur_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_delay_line_controller.sv
// Directed and randomized sequences against a sample-history model of the delay line.
module tb_delay_line_controller;
  import delay_line_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          sample_tick;
  logic [DW-1:0] adc_data;
  logic [AW-1:0] delay_set;
  logic          delay_load;
  logic [DW-1:0] ram_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] dac_data;
  logic          dac_valid;
  logic          busy;
  logic          overrun;
  logic [AW-1:0] delay_cur;
  state_e        dbg_state;

  delay_line_controller #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .qzt_clk    (clk),
    .reset      (reset),
    .sample_tick(sample_tick),
    .adc_data   (adc_data),
    .delay_set  (delay_set),
    .delay_load (delay_load),
    .ram_rdata  (ram_rdata),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .dac_data   (dac_data),
    .dac_valid  (dac_valid),
    .busy       (busy),
    .overrun    (overrun),
    .delay_cur  (delay_cur),
    .dbg_state  (dbg_state)
  );

  delay_line_ram #(.ADDR_W(AW), .DATA_W(DW)) ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  // scoreboard: every sample ever written since reset, plus the delay in force
  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] hist[$];
  int            m_writes;
  int            m_wp;
  int            m_delay;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_writes = 0;
    m_wp     = 0;
    m_delay  = 16;
  endtask

  // driver tasks
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; sample_tick = 1'b0; delay_load = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic load_delay(input int v);
    @(posedge clk); #1;
    delay_set = AW'(v); delay_load = 1'b1;
    @(posedge clk); #1;
    delay_load = 1'b0;
    m_delay = v;
    @(negedge clk);
    check("delay_cur_idle_load", 32'(delay_cur), 32'(v));
  endtask

  // One full tick sequence; strobe_k places a delay_load in cycle T+strobe_k (-1: none).
  task automatic run_seq(input logic [DW-1:0] data, input int strobe_k, input int strobe_val);
    int n;
    int new_delay;
    logic [AW-1:0] exp_rd;
    logic [DW-1:0] exp_dac;
    n = m_writes;
    hist.push_back(data);
    exp_rd    = AW'((m_wp - m_delay) & 255);
    exp_dac   = (n + 1 > m_delay) ? hist[n - m_delay] : '0;
    new_delay = (strobe_k >= 1 && strobe_k <= 4) ? strobe_val : m_delay;
    @(posedge clk); #1;
    sample_tick = 1'b1; adc_data = data;
    for (int k = 0; k < 10; k++) begin
      delay_load = (k == strobe_k);
      if (k == strobe_k) delay_set = AW'(strobe_val);
      if (k == 2) sample_tick = 1'b0;
      @(negedge clk);
      case (k)
        0: check("busy_edge_cycle", 32'(busy), 32'd0);
        1: begin
          check("busy_wr", 32'(busy), 32'd1);
          check("we_wr", 32'(ram_we), 32'd1);
          check("addr_wr", 32'(ram_addr), 32'(m_wp));
          check("wdata_wr", 32'(ram_wdata), 32'(data));
        end
        2: begin
          check("we_rd", 32'(ram_we), 32'd0);
          check("addr_rd", 32'(ram_addr), 32'(exp_rd));
        end
        3: begin
          check("valid_early", 32'(dac_valid), 32'd0);
          check("delay_cur_rw", 32'(delay_cur), 32'(m_delay));
        end
        4: begin
          check("valid_t4", 32'(dac_valid), 32'd1);
          check("dac_data", 32'(dac_data), 32'(exp_dac));
          check("delay_cur_out", 32'(delay_cur), 32'(m_delay));
        end
        5: begin
          check("valid_pulse_end", 32'(dac_valid), 32'd0);
          check("dac_hold", 32'(dac_data), 32'(exp_dac));
          check("busy_done", 32'(busy), 32'd0);
          check("delay_cur_after", 32'(delay_cur), 32'(new_delay));
        end
        default: ;
      endcase
      @(posedge clk); #1;
    end
    delay_load = 1'b0;
    m_writes++;
    m_wp    = (m_wp + 1) % 256;
    m_delay = new_delay;
  endtask

  initial begin
    int we_cnt;
    int valid_cnt;
    int busy_cnt;
    int sk;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_dac;

    reset = 1'b1; sample_tick = 1'b0; adc_data = '0; delay_set = '0; delay_load = 1'b0;
    do_reset();

    // reset values
    @(negedge clk);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check("rst_dac_data", 32'(dac_data), 32'd0);
    check("rst_dac_valid", 32'(dac_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_delay_cur", 32'(delay_cur), 32'd16);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // delay 3, samples 1..8
    load_delay(3);
    for (int i = 1; i <= 8; i++) run_seq(DW'(i), -1, 0);

    // delay 0 pass-through
    load_delay(0);
    run_seq(8'h5A, -1, 0);

    // long run at delay 255 with address wrap
    do_reset();
    load_delay(255);
    for (int i = 0; i < 300; i++) run_seq(DW'($urandom_range(0, 255)), -1, 0);

    // busy-time delay strobes: RW, WR and OUT cycles
    run_seq(DW'($urandom_range(0, 255)), 3, 5);
    run_seq(DW'($urandom_range(0, 255)), -1, 0);
    run_seq(DW'($urandom_range(0, 255)), 1, 9);
    run_seq(DW'($urandom_range(0, 255)), 4, 2);
    run_seq(DW'($urandom_range(0, 255)), -1, 0);

    // second edge two cycles after the first
    d = DW'($urandom_range(0, 255));
    hist.push_back(d);
    exp_dac = (m_writes + 1 > m_delay) ? hist[m_writes - m_delay] : '0;
    we_cnt = 0; valid_cnt = 0;
    @(posedge clk); #1;
    sample_tick = 1'b1; adc_data = d;
    for (int k = 0; k < 12; k++) begin
      if (k == 1) sample_tick = 1'b0;
      if (k == 2) begin sample_tick = 1'b1; adc_data = ~d; end
      if (k == 3) sample_tick = 1'b0;
      @(negedge clk);
      if (ram_we) we_cnt++;
      if (dac_valid) valid_cnt++;
      if (k == 4) check("ovr_dac_data", 32'(dac_data), 32'(exp_dac));
      @(posedge clk); #1;
    end
    check("ovr_write_count", 32'(we_cnt), 32'd1);
    check("ovr_valid_count", 32'(valid_cnt), 32'd1);
    check("ovr_flag_set", 32'(overrun), 32'd1);
    m_writes++;
    m_wp = (m_wp + 1) % 256;
    run_seq(DW'($urandom_range(0, 255)), -1, 0);
    @(negedge clk);
    check("ovr_sticky", 32'(overrun), 32'd1);
    do_reset();
    @(negedge clk);
    check("ovr_cleared", 32'(overrun), 32'd0);

    // reset in RD with the tick held high across reset release
    load_delay(1);
    run_seq(8'h11, -1, 0);
    valid_cnt = 0; busy_cnt = 0;
    @(posedge clk); #1;
    sample_tick = 1'b1; adc_data = 8'h22;
    for (int k = 0; k < 12; k++) begin
      if (k == 2) reset = 1'b1;
      if (k == 3) reset = 1'b0;
      if (k == 10) sample_tick = 1'b0;
      @(negedge clk);
      if (k == 2) check("rstmid_in_rd", 32'(dbg_state), 32'(RD));
      if (k == 3) begin
        check("rstmid_idle", 32'(dbg_state), 32'(IDLE));
        check("rstmid_we", 32'(ram_we), 32'd0);
      end
      if (k >= 3 && dac_valid) valid_cnt++;
      if (k >= 3 && busy) busy_cnt++;
      @(posedge clk); #1;
    end
    check("rstmid_no_valid", 32'(valid_cnt), 32'd0);
    check("held_tick_no_start", 32'(busy_cnt), 32'd0);
    check("rstmid_delay_cur", 32'(delay_cur), 32'd16);
    model_reset();
    run_seq(DW'($urandom_range(0, 255)), -1, 0);

    // random delays and strobe placement
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 0) load_delay($urandom_range(0, 12));
      case ($urandom_range(0, 3))
        0: sk = 1;
        1: sk = 3;
        2: sk = 4;
        default: sk = -1;
      endcase
      run_seq(DW'($urandom_range(0, 255)), sk, $urandom_range(0, 12));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
